nbody_bus_slave: RTL and testbench
==================================

Name: nbody_bus_slave

Overview:
- Bus-side responder front-end for the nbody accelerator. Decodes the host's 16-bit-address, 32-bit-half-word register/memory protocol and turns it into core-facing control registers, 64-bit body-memory writes and result reads.
- Pairs 32-bit lower/upper half writes into IEEE-754 doubles, sequences GO/run/done, and returns results with fixed read latency.
- Sits between the HPS bridge and the nbody compute core.

Parameters:
ADDR_WIDTH, 16, bus address width
BODY_ADDR_WIDTH, 9, body index bits (addr[8:0]); max 512 bodies
DATA_WIDTH, 64, bus data width; only [31:0] carries memory half-words

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
chipselect  in  1  bus select
read  in  1  read strobe, qualified by chipselect
write  in  1  write strobe, qualified by chipselect
addr  in  16  sel = addr[15:9], idx = addr[8:0]
writedata  in  64  write data
readdata  out  64  read data, registered
mem_we  out  1  one-cycle body-memory write strobe
mem_field  out  3  0=X 1=Y 2=M 3=VX 4=VY
mem_idx  out  9  body index
mem_wdata  out  64  assembled double {upper, lower}
n_bodies  out  10  body count register
gap  out  32  step-gap register
start  out  1  one-cycle run pulse to core
read_mode  out  1  READ register bit0 (core exposes results)
core_done  in  1  level from core: run finished
res_addr  out  9  result index (combinational from addr[8:0])
res_sel  out  1  0=X 1=Y
res_rdata  in  64  result double, valid 1 cycle after res_addr

Behaviour:
- Reset (rst=0, async): all outputs 0. State IDLE, staging invalid, err=0.
- Write decode (chipselect&write), by sel:
  - 0x00 GO
  - 0x01 READ: read_mode <= wd[0]
  - 0x02 N_BODIES: n_bodies <= wd[9:0]
  - 0x03 GAP: gap <= wd[31:0]
  - 0x04/05 X lo/hi; 0x06/07 Y; 0x08/09 M; 0x10/11 VX; 0x12/13 VY
  - 0x40: clears err
  - Any other sel: ignored, no side effects.
- Lower-half write: stage_data <= wd[31:0]; stage_field, stage_idx latched; stage_valid=1. A second lower write overwrites the staging.
- Upper-half write:
  - If stage_valid, field matches and idx matches: the next cycle emits mem_we=1, mem_wdata={wd[31:0], stage_data}, mem_field, mem_idx. stage_valid<=0.
  - Otherwise: no write, err<=1, stage_valid<=0.
- Body-memory and N_BODIES/GAP writes while state RUN: ignored, err<=1.
- State machine:
  - IDLE -> RUN on GO write with wd[0]=1 and n_bodies!=0. start=1 for exactly the following cycle.
  - GO=1 with n_bodies=0: stay IDLE, err<=1.
  - RUN -> DONE when core_done=1. GO writes in RUN are ignored.
  - DONE -> IDLE on GO write with wd[0]=0.
  - GO wd[0]=0 in IDLE: no-op.
- Read decode (chipselect&read), sel:
  - 0x40 status: bit0 done (state==DONE), bit1 busy (RUN), bit2 err
  - 0x41 X lo, 0x42 X hi, 0x43 Y lo, 0x44 Y hi
  - 0x00-0x03: readback of GO level, read_mode, n_bodies, gap
  - Other sel: returns 0.
- Read latency: 2 cycles for every read. Read accepted in cycle t; res_addr/res_sel driven during t; res_rdata sampled at end of t+1; readdata valid from t+2 and held until the next accepted read's update.
  - Lo reads return {32'b0, res_rdata[31:0]}; hi reads return {32'b0, res_rdata[63:32]}.
- Reads are pipelined: back-to-back reads each cycle produce back-to-back results.
- Simultaneous read&write in one cycle: write takes effect; read is ignored (readdata unchanged).
- Reset mid-RUN returns to IDLE with start=0, losing staging; the core is reset separately.

Test Plan:
- Reset, then read sel 0x40 -> readdata=0 at t+2; all outputs 0.
- Write X lo idx 2 = 0x00000000, then X hi idx 2 = 0x3FF00000 -> one cycle mem_we=1, mem_field=0, mem_idx=2, mem_wdata=0x3FF0000000000000 (1.0).
- Lower-half write Y idx 1, then upper-half write Y idx 2 -> no mem_we; status bit2=1. Write 0x40 -> bit2=0.
- N_BODIES=25, GAP=6, GO=1 -> start pulse exactly one cycle, status=0x2. Raise core_done -> status=0x1. GO=0 -> status=0x0.
- GO=1 with n_bodies=0 -> no start, err=1. Memory write during RUN -> mem_we stays 0, err=1.
- Back-to-back reads 0x41/0x42 idx 0 with res_rdata=0xC014000000000000 -> readdata 0x0 then 0xC0140000 on consecutive cycles, starting 2 cycles after the first read.

Source files
------------

// File: rtl/nbody_bus_slave.sv
// rtl/nbody_bus_slave.sv - bus-side register/memory responder for the nbody accelerator
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   chipselect, read, write, addr, writedata, readdata
//                    host bus; sel = addr[15:9], idx = addr[8:0]; readdata has 2-cycle latency
//   mem_we, mem_field, mem_idx, mem_wdata
//                    one-cycle 64-bit body-memory write to the core
//   n_bodies, gap, start, read_mode
//                    core control registers and run pulse
//   core_done        level from core: run finished
//   res_addr, res_sel, res_rdata
//                    result read port; res_rdata valid one cycle after res_addr/res_sel
module nbody_bus_slave #(
  parameter int ADDR_WIDTH      = 16,
  parameter int BODY_ADDR_WIDTH = 9,
  parameter int DATA_WIDTH      = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       chipselect,
  input  logic                       read,
  input  logic                       write,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]      writedata,
  output logic [DATA_WIDTH-1:0]      readdata,
  output logic                       mem_we,
  output logic [2:0]                 mem_field,
  output logic [BODY_ADDR_WIDTH-1:0] mem_idx,
  output logic [63:0]                mem_wdata,
  output logic [9:0]                 n_bodies,
  output logic [31:0]                gap,
  output logic                       start,
  output logic                       read_mode,
  input  logic                       core_done,
  output logic [BODY_ADDR_WIDTH-1:0] res_addr,
  output logic                       res_sel,
  input  logic [63:0]                res_rdata
);

  localparam int SEL_W = ADDR_WIDTH - BODY_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {RD_REG, RD_LO, RD_HI} rd_kind_t;

  state_t                     state;
  logic                       err;
  logic                       go_level;

  logic                       stage_valid;
  logic [31:0]                stage_data;
  logic [2:0]                 stage_field;
  logic [BODY_ADDR_WIDTH-1:0] stage_idx;

  logic                       rd_v;
  rd_kind_t                   rd_kind;
  logic [DATA_WIDTH-1:0]      rd_reg;

  logic [SEL_W-1:0]           sel;
  logic [BODY_ADDR_WIDTH-1:0] idx;
  logic                       wr_acc;
  logic                       rd_acc;

  logic                       body_hit;
  logic                       body_hi;
  logic [2:0]                 body_field;

  rd_kind_t                   rd_kind_c;
  logic [DATA_WIDTH-1:0]      rd_reg_c;

  logic                       unused_bits;

  assign sel    = addr[ADDR_WIDTH-1:BODY_ADDR_WIDTH];
  assign idx    = addr[BODY_ADDR_WIDTH-1:0];
  assign wr_acc = chipselect & write;
  // A write in the same cycle wins; the read is dropped.
  assign rd_acc = chipselect & read & ~write;

  assign res_addr    = idx;
  assign res_sel     = (sel == SEL_W'(7'h43)) || (sel == SEL_W'(7'h44));
  assign unused_bits = ^writedata[DATA_WIDTH-1:32];

  // Body-memory half-word decode: odd sel is the upper half.
  always_comb begin
    body_hit   = 1'b1;
    body_field = 3'd0;
    body_hi    = sel[0];
    case (sel)
      SEL_W'(7'h04), SEL_W'(7'h05): body_field = 3'd0;
      SEL_W'(7'h06), SEL_W'(7'h07): body_field = 3'd1;
      SEL_W'(7'h08), SEL_W'(7'h09): body_field = 3'd2;
      SEL_W'(7'h10), SEL_W'(7'h11): body_field = 3'd3;
      SEL_W'(7'h12), SEL_W'(7'h13): body_field = 3'd4;
      default:                      body_hit   = 1'b0;
    endcase
  end

  // Read decode; register values are captured in the accept cycle,
  // result halves are picked from res_rdata one cycle later.
  always_comb begin
    rd_kind_c = RD_REG;
    rd_reg_c  = '0;
    case (sel)
      SEL_W'(7'h00): rd_reg_c = DATA_WIDTH'(go_level);
      SEL_W'(7'h01): rd_reg_c = DATA_WIDTH'(read_mode);
      SEL_W'(7'h02): rd_reg_c = DATA_WIDTH'(n_bodies);
      SEL_W'(7'h03): rd_reg_c = DATA_WIDTH'(gap);
      SEL_W'(7'h40): rd_reg_c = DATA_WIDTH'({err, state == RUN, state == DONE});
      SEL_W'(7'h41), SEL_W'(7'h43): rd_kind_c = RD_LO;
      SEL_W'(7'h42), SEL_W'(7'h44): rd_kind_c = RD_HI;
      default: rd_reg_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      err         <= 1'b0;
      go_level    <= 1'b0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
      stage_field <= '0;
      stage_idx   <= '0;
      mem_we      <= 1'b0;
      mem_field   <= '0;
      mem_idx     <= '0;
      mem_wdata   <= '0;
      n_bodies    <= '0;
      gap         <= '0;
      start       <= 1'b0;
      read_mode   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      start  <= 1'b0;

      if (state == RUN && core_done) state <= DONE;

      if (wr_acc) begin
        case (sel)
          SEL_W'(7'h00): begin
            go_level <= writedata[0];
            if (state == IDLE && writedata[0]) begin
              if (n_bodies != '0) begin
                state <= RUN;
                start <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end else if (state == DONE && !writedata[0]) begin
              state <= IDLE;
            end
          end
          SEL_W'(7'h01): read_mode <= writedata[0];
          SEL_W'(7'h02): begin
            if (state == RUN) err <= 1'b1;
            else              n_bodies <= writedata[9:0];
          end
          SEL_W'(7'h03): begin
            if (state == RUN) err <= 1'b1;
            else              gap <= writedata[31:0];
          end
          SEL_W'(7'h40): err <= 1'b0;
          default: begin
            if (body_hit) begin
              if (state == RUN) begin
                err <= 1'b1;
              end else if (!body_hi) begin
                stage_valid <= 1'b1;
                stage_data  <= writedata[31:0];
                stage_field <= body_field;
                stage_idx   <= idx;
              end else begin
                stage_valid <= 1'b0;
                if (stage_valid && stage_field == body_field && stage_idx == idx) begin
                  mem_we    <= 1'b1;
                  mem_field <= body_field;
                  mem_idx   <= idx;
                  mem_wdata <= {writedata[31:0], stage_data};
                end else begin
                  err <= 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  // Two-stage read pipeline: accept -> result sample -> readdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v     <= 1'b0;
      rd_kind  <= RD_REG;
      rd_reg   <= '0;
      readdata <= '0;
    end else begin
      rd_v <= rd_acc;
      if (rd_acc) begin
        rd_kind <= rd_kind_c;
        rd_reg  <= rd_reg_c;
      end
      if (rd_v) begin
        case (rd_kind)
          RD_LO:   readdata <= DATA_WIDTH'(res_rdata[31:0]);
          RD_HI:   readdata <= DATA_WIDTH'(res_rdata[63:32]);
          default: readdata <= rd_reg;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nbody_bus_slave.sv
// tb/tb_nbody_bus_slave.sv - directed-vector bench for nbody_bus_slave
module tb_nbody_bus_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chipselect, read, write;
  logic [15:0] addr;
  logic [63:0] writedata;
  logic [63:0] readdata;
  logic        mem_we;
  logic [2:0]  mem_field;
  logic [8:0]  mem_idx;
  logic [63:0] mem_wdata;
  logic [9:0]  n_bodies;
  logic [31:0] gap;
  logic        start;
  logic        read_mode;
  logic        core_done;
  logic [8:0]  res_addr;
  logic        res_sel;
  logic [63:0] res_rdata;

  logic [63:0] res_x_val, res_y_val;
  logic [63:0] q, q2;
  int vectors = 0;
  int miscompares = 0;

  nbody_bus_slave dut (
    .clk(clk), .rst(rst_n), .chipselect(chipselect), .read(read), .write(write),
    .addr(addr), .writedata(writedata), .readdata(readdata),
    .mem_we(mem_we), .mem_field(mem_field), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
    .n_bodies(n_bodies), .gap(gap), .start(start), .read_mode(read_mode),
    .core_done(core_done), .res_addr(res_addr), .res_sel(res_sel), .res_rdata(res_rdata)
  );

  always #5 clk = ~clk;

  // Core result memory stand-in: one cycle of read latency.
  always @(posedge clk) res_rdata <= res_sel ? res_y_val : res_x_val;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [6:0] s, input logic [8:0] i, input logic [63:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; addr = {s, i}; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [6:0] s, input logic [8:0] i, output logic [63:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; addr = {s, i};
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    @(posedge clk); #1;
    d = readdata;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    chipselect = 0; read = 0; write = 0; addr = '0; writedata = '0; core_done = 0;
    res_x_val = 64'hC014000000000000;
    res_y_val = 64'h400921FB54442D18;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, 64'h0);
    chk("rst_mem_we", {63'b0, mem_we}, 64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_n_bodies", {54'b0, n_bodies}, 64'h0);
    chk("rst_gap", {32'b0, gap}, 64'h0);
    chk("rst_start", {63'b0, start}, 64'h0);
    chk("rst_read_mode", {63'b0, read_mode}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    bus_rd(7'h40, 9'd0, q);
    chk("rst_status", q, 64'h0);

    // Paired X write, idx 2 -> 1.0
    bus_wr(7'h04, 9'd2, 64'h0);
    chk("xlo_no_we", {63'b0, mem_we}, 64'h0);
    bus_wr(7'h05, 9'd2, 64'h3FF00000);
    chk("x_we", {63'b0, mem_we}, 64'h1);
    chk("x_field", {61'b0, mem_field}, 64'h0);
    chk("x_idx", {55'b0, mem_idx}, 64'd2);
    chk("x_wdata", mem_wdata, 64'h3FF0000000000000);
    tick;
    chk("x_we_one_cycle", {63'b0, mem_we}, 64'h0);

    // Second lower write overwrites staging (M idx 4)
    bus_wr(7'h08, 9'd4, 64'h0000AAAA);
    bus_wr(7'h08, 9'd4, 64'h0000BBBB);
    bus_wr(7'h09, 9'd4, 64'h00000001);
    chk("m_we", {63'b0, mem_we}, 64'h1);
    chk("m_field", {61'b0, mem_field}, 64'd2);
    chk("m_wdata", mem_wdata, 64'h000000010000BBBB);

    // VY at top index
    bus_wr(7'h12, 9'd511, 64'h11111111);
    bus_wr(7'h13, 9'd511, 64'h22222222);
    chk("vy_we", {63'b0, mem_we}, 64'h1);
    chk("vy_field", {61'b0, mem_field}, 64'd4);
    chk("vy_idx", {55'b0, mem_idx}, 64'd511);
    chk("vy_wdata", mem_wdata, 64'h2222222211111111);

    // Index mismatch on upper half
    bus_wr(7'h06, 9'd1, 64'h12345678);
    bus_wr(7'h07, 9'd2, 64'h9ABCDEF0);
    chk("mismatch_no_we", {63'b0, mem_we}, 64'h0);
    bus_rd(7'h40, 9'd0, q);
    chk("mismatch_err", q, 64'h4);
    bus_wr(7'h40, 9'd0, 64'h0);
    bus_rd(7'h40, 9'd0, q);
    chk("err_cleared", q, 64'h0);

    // Normal run sequence
    bus_wr(7'h02, 9'd0, 64'd25);
    bus_wr(7'h03, 9'd0, 64'd6);
    bus_rd(7'h02, 9'd0, q);
    chk("rb_n_bodies", q, 64'd25);
    bus_rd(7'h03, 9'd0, q);
    chk("rb_gap", q, 64'd6);
    bus_wr(7'h00, 9'd0, 64'h1);
    chk("start_pulse", {63'b0, start}, 64'h1);
    tick;
    chk("start_one_cycle", {63'b0, start}, 64'h0);
    bus_rd(7'h40, 9'd0, q);
    chk("status_busy", q, 64'h2);
    @(negedge clk); core_done = 1'b1;
    @(negedge clk); core_done = 1'b0;
    bus_rd(7'h40, 9'd0, q);
    chk("status_done", q, 64'h1);
    bus_wr(7'h00, 9'd0, 64'h0);
    bus_rd(7'h40, 9'd0, q);
    chk("status_idle", q, 64'h0);

    // GO with zero bodies
    bus_wr(7'h02, 9'd0, 64'd0);
    bus_wr(7'h00, 9'd0, 64'h1);
    chk("go_zero_no_start", {63'b0, start}, 64'h0);
    bus_rd(7'h40, 9'd0, q);
    chk("go_zero_err", q, 64'h4);
    bus_wr(7'h40, 9'd0, 64'h0);

    // Writes during RUN are rejected
    bus_wr(7'h02, 9'd0, 64'd3);
    bus_wr(7'h00, 9'd0, 64'h1);
    chk("run2_start", {63'b0, start}, 64'h1);
    bus_wr(7'h04, 9'd0, 64'h5);
    bus_wr(7'h05, 9'd0, 64'h6);
    chk("run_mem_no_we", {63'b0, mem_we}, 64'h0);
    bus_wr(7'h02, 9'd0, 64'd9);
    bus_rd(7'h02, 9'd0, q);
    chk("run_nbodies_kept", q, 64'd3);
    bus_rd(7'h40, 9'd0, q);
    chk("run_err", q, 64'h6);
    @(negedge clk); core_done = 1'b1;
    @(negedge clk); core_done = 1'b0;
    bus_wr(7'h40, 9'd0, 64'h0);
    bus_wr(7'h00, 9'd0, 64'h0);
    bus_rd(7'h40, 9'd0, q);
    chk("run2_idle", q, 64'h0);

    // Result port addressing and Y hi read
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; addr = {7'h44, 9'd300};
    #1;
    chk("res_addr", {55'b0, res_addr}, 64'd300);
    chk("res_sel_y", {63'b0, res_sel}, 64'h1);
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    tick;
    chk("y_hi", readdata, 64'h400921FB);

    // Back-to-back X lo/hi reads
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; addr = {7'h41, 9'd0};
    @(posedge clk); #1;
    chk("b2b_hold", readdata, 64'h400921FB);
    addr = {7'h42, 9'd0};
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    q = readdata;
    tick;
    q2 = readdata;
    chk("b2b_lo", q, 64'h0);
    chk("b2b_hi", q2, 64'h00000000C0140000);

    // Simultaneous read and write: write wins, readdata unchanged
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b1; addr = {7'h02, 9'd0}; writedata = 64'd7;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    tick; tick;
    chk("rw_readdata_held", readdata, 64'h00000000C0140000);
    chk("rw_write_done", {54'b0, n_bodies}, 64'd7);

    // Unmapped sel
    bus_rd(7'h7F, 9'd0, q);
    chk("unmapped_read", q, 64'h0);
    bus_wr(7'h7F, 9'd0, 64'hFFFF);
    bus_rd(7'h40, 9'd0, q);
    chk("unmapped_write", q, 64'h0);

    // Reset mid-RUN
    bus_wr(7'h00, 9'd0, 64'h1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrun_rst_start", {63'b0, start}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    bus_rd(7'h40, 9'd0, q);
    chk("midrun_rst_status", q, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
